sprite_dma: RTL
===============

# sprite_dma

Copies the 128-byte sprite attribute table (32 sprites × 4 bytes) from CPU work RAM into sprite RAM during vertical blank. It sits directly upstream of the sprite engine and is the only writer of sprite RAM, so sprite RAM never changes while visible lines are being drawn. The CPU arms a transfer with a start pulse and a source base address; the block requests the CPU bus at the next vblank rising edge and streams one byte per granted cycle.

## Interface
- `TABLE_BYTES`, default 128: bytes per transfer; must be a power of two ≤ 128.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `vblank` in 1: vertical blank from the video timing generator.
- `start` in 1: single-cycle arm request from the CPU register decode.
- `src_base` in 16: CPU RAM source address, latched on `start`.
- `dma_ack` in 1: CPU bus grant; may drop at any time.
- `src_data_in` in 8: CPU RAM read data, valid one cycle after `src_addr`.
- `dma_req` out 1: CPU bus request.
- `src_addr` out 16: CPU RAM read address.
- `spriteram_wr_addr` out 7: sprite RAM write address.
- `spriteram_wr` out 1: sprite RAM write strobe.
- `spriteram_data_in` out 8: sprite RAM write data.
- `busy` out 1: high while armed or transferring.
- `done` out 1: one-cycle pulse after the final write.
- `overrun` out 1: sticky flag, cleared by the next `start`.

## Operation
- On reset, every output is 0, the state is `IDLE`, and the internal `vblank_last` register is 0.
- `IDLE`: when `start` is sampled high, latch `src_base`, clear `overrun`, set `busy`, and go to `ARMED`.
- `ARMED`: a `start` pulse re-latches `src_base`. On a vblank rising edge (`vblank` high and `vblank_last` low), zero the issue and write counters, set `dma_req`, and go to `XFER`.
- `XFER`:
  - A read issues on each edge where `dma_req` and `dma_ack` are both high and `issue_cnt < TABLE_BYTES`. `src_addr` is `src_base + issue_cnt`, wrapping mod 2^16. `issue_cnt` increments on each issue.
  - Each issued read sets a one-deep `rd_valid` pipeline bit. On the following edge, register `spriteram_wr=1`, `spriteram_wr_addr=wr_cnt[6:0]` and `spriteram_data_in=src_data_in`, then increment `wr_cnt`.
  - When `dma_ack` is low, issuing stops. `src_addr` holds its value and a read already in flight still completes its write.
  - `dma_req` drops on the edge of the last issue.
  - When `wr_cnt` reaches `TABLE_BYTES`, go to `DONE`.
- `DONE`: pulse `done` for one cycle, clear `busy`, return to `IDLE`.
- Abort: if `vblank` falls while in `XFER`, drop `dma_req`, let any in-flight write finish, set `overrun`, and go to `IDLE` without pulsing `done`. Sprite RAM then holds a partial table.
- `start` is ignored while in `XFER` or `DONE`.
- If `start` and a vblank rising edge arrive in the same cycle in `IDLE`, only the arm is taken. The transfer then waits for the next vblank.
- Asserting reset at any point aborts immediately. No further write strobes occur and all outputs go to 0 asynchronously.

## Timing
- The vblank edge detect has 1 cycle of latency, so `dma_req` rises on the edge after the one where `vblank` is first sampled high.
- Read-to-write latency is 1 cycle: a read issued at edge E writes sprite RAM with strobe high during the cycle after edge E+1.
- With `dma_ack` held high, a full 128-byte transfer takes 128 issue cycles plus 1 write cycle, then `done`. Total is about 131 cycles from `dma_req` rising to `done`, well within vblank.
- `spriteram_wr` is high for exactly one cycle per byte. Addresses run 0..`TABLE_BYTES`-1 with no gaps or repeats.

## Configuration
- `SPRITE_DMA_CHECKSUM_EN`:
  - Defined: adds output `checksum[7:0]`. It is cleared when `XFER` is entered and XORed with each written byte. It is valid from `done` until the next transfer starts, and held through an abort.
  - Undefined: the port is absent and no checksum logic is built.

## Test plan
- Arm with `src_base=0x4000`, hold `dma_ack=1`, raise `vblank`: expect 128 writes with sprite RAM addresses 0..127 carrying RAM[0x4000..0x407F], then a single `done` pulse and `busy=0`.
- Toggle `dma_ack` low for 5 cycles at byte 40: expect `src_addr` held at 0x4028 during the stall, no duplicated or skipped addresses, and still exactly 128 writes.
- Drop `vblank` after 60 writes: expect `dma_req=0` on the next edge, at most one further write, `overrun=1`, no `done`, and `overrun` cleared by the next `start`.
- Arm with `src_base=0xFFF0`: expect `src_addr` to wrap to 0x0000 at byte 16, with sprite RAM addresses 16..127 continuing uninterrupted.
- Pulse `start` with `src_base=0x5000` while in `XFER`: expect it ignored and the transfer to finish from the original base. Separately, pulse `reset_n` low mid-transfer: expect all outputs 0 immediately and no writes afterwards.
- With `SPRITE_DMA_CHECKSUM_EN` defined and a table of 0x01..0x80: expect `checksum=0x80` at `done`.

Source files
------------

// File: rtl/sprite_dma.sv
// sprite_dma: copies the sprite attribute table from CPU RAM into sprite RAM during vblank.
// Optional feature macro: SPRITE_DMA_CHECKSUM_EN adds an XOR checksum output of the written bytes.
module sprite_dma #(
  parameter int TABLE_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vblank,
  input  logic        start,
  input  logic [15:0] src_base,
  input  logic        dma_ack,
  input  logic [7:0]  src_data_in,
  output logic        dma_req,
  output logic [15:0] src_addr,
  output logic [6:0]  spriteram_wr_addr,
  output logic        spriteram_wr,
  output logic [7:0]  spriteram_data_in,
  output logic        busy,
  output logic        done,
  output logic        overrun
`ifdef SPRITE_DMA_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, XFER, DONE} state_t;
  localparam logic [7:0] TB8 = 8'(TABLE_BYTES);
  localparam logic [7:0] LAST = 8'(TABLE_BYTES - 1);
  state_t state;
  logic [15:0] base;
  logic [7:0] issue_cnt, wr_cnt;
  logic vblank_last, rise_pend, rd_valid, issue;
  // A read only issues while the bus is granted and vblank is still open
  assign issue = state == XFER && dma_req && dma_ack && vblank && issue_cnt < TB8;
  assign src_addr = base + {8'h00, issue_cnt};
  // Control FSM; the vblank rise is registered first, giving one cycle of detect latency
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      base <= '0;
      issue_cnt <= '0;
      wr_cnt <= '0;
      vblank_last <= 1'b0;
      rise_pend <= 1'b0;
      dma_req <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      vblank_last <= vblank;
      rise_pend <= state == ARMED && vblank && !vblank_last;
      done <= 1'b0;
      if (rd_valid) wr_cnt <= wr_cnt + 8'd1;
      case (state)
        IDLE:
          if (start) begin
            base <= src_base;
            overrun <= 1'b0;
            busy <= 1'b1;
            state <= ARMED;
          end
        ARMED: begin
          if (start) base <= src_base;
          if (rise_pend) begin
            issue_cnt <= '0;
            wr_cnt <= '0;
            dma_req <= 1'b1;
            state <= XFER;
          end
        end
        XFER: begin
          if (issue) begin
            issue_cnt <= issue_cnt + 8'd1;
            if (issue_cnt == LAST) dma_req <= 1'b0;
          end
          if (wr_cnt == TB8) state <= DONE;
          else if (!vblank) begin
            dma_req <= 1'b0;
            overrun <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  // Write stage: the byte returned one cycle after its read is stored in sprite RAM
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_valid <= 1'b0;
      spriteram_wr <= 1'b0;
      spriteram_wr_addr <= '0;
      spriteram_data_in <= '0;
    end else begin
      rd_valid <= issue;
      spriteram_wr <= rd_valid;
      if (rd_valid) begin
        spriteram_wr_addr <= wr_cnt[6:0];
        spriteram_data_in <= src_data_in;
      end
    end
`ifdef SPRITE_DMA_CHECKSUM_EN
  // Running XOR of the bytes written in the current transfer, held after it ends
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) checksum <= '0;
    else if (state == ARMED && rise_pend) checksum <= '0;
    else if (rd_valid) checksum <= checksum ^ src_data_in;
`endif
endmodule
